// File: rtl/slave_control.sv
// Slave side of the two-wire request/ack chip-to-chip link: synchronizes the master's
// wires, acknowledges requests, captures the payload once valid is stable and lights a notice LED.
module slave_control #(
    parameter int unsigned DATA_W         = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned NOTICE_CYCLES  = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              request,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_strobe,
    output logic              notice,
    output logic              timeout_err
);

    localparam int unsigned NOTICE_W  = $clog2(NOTICE_CYCLES) + 1;
    localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAck     = 2'd1,
        StRelease = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]             r_req_sync;
    logic [SYNC_STAGES-1:0]             r_val_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_dat_sync;

    state_t                r_state;
    logic                  r_ack;
    logic [DATA_W-1:0]     r_data;
    logic                  r_strobe;
    logic                  r_timeout_err;
    logic                  r_val_seen;
    logic [TIMEOUT_W-1:0]  r_to_cnt;
    logic [NOTICE_W-1:0]   r_notice_cnt;

    logic                  w_req_s;
    logic                  w_val_s;
    logic [DATA_W-1:0]     w_dat_s;
    logic                  w_capture;
    logic                  w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_sync <= '0;
            r_val_sync <= '0;
            r_dat_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], request};
            r_val_sync <= {r_val_sync[SYNC_STAGES-2:0], valid};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], data_in};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_val_s = r_val_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

    // Valid must be seen on two consecutive cycles so inter-wire skew cannot corrupt the capture.
    assign w_capture = (r_state == StAck) && w_val_s && r_val_seen;
    assign w_timeout = (r_state == StAck) && !w_capture &&
                       (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_ack         <= 1'b0;
            r_data        <= '0;
            r_strobe      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_val_seen    <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_to_cnt   <= '0;
                    r_val_seen <= 1'b0;
                    if (w_req_s) begin
                        r_state <= StAck;
                        r_ack   <= 1'b1;
                    end
                end
                StAck: begin
                    if (w_capture) begin
                        r_data        <= w_dat_s;
                        r_strobe      <= 1'b1;
                        r_timeout_err <= 1'b0;
                        r_ack         <= 1'b0;
                        r_val_seen    <= 1'b0;
                        r_state       <= StRelease;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_ack         <= 1'b0;
                        r_val_seen    <= 1'b0;
                        r_state       <= StRelease;
                    end else begin
                        r_to_cnt   <= r_to_cnt + TIMEOUT_W'(1);
                        r_val_seen <= w_val_s;
                    end
                end
                StRelease: begin
                    r_val_seen <= 1'b0;
                    // Master holds valid until it sees ack low; wait for both wires to clear.
                    if (!w_req_s && !w_val_s) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_notice_cnt <= '0;
        end else if (w_capture) begin
            r_notice_cnt <= NOTICE_W'(NOTICE_CYCLES);
        end else if (r_notice_cnt != '0) begin
            r_notice_cnt <= r_notice_cnt - NOTICE_W'(1);
        end
    end

    assign ack         = r_ack;
    assign data_out    = r_data;
    assign data_strobe = r_strobe;
    assign notice      = (r_notice_cnt != '0);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_slave_control.sv
// Directed bench for slave_control: a master model drives the handshake, expected payloads go
// into a queue and a monitor pops and compares them on every data_strobe.
module tb_slave_control;

    logic       clk;
    logic       rst_n;
    logic       request;
    logic       valid;
    logic [2:0] data_in;
    logic       ack;
    logic [2:0] data_out;
    logic       data_strobe;
    logic       notice;
    logic       timeout_err;

    int         n_checks;
    int         n_fail;
    int         n_strobes;
    int         n_pushed;
    logic [2:0] exp_q[$];
    logic [2:0] last_data;

    slave_control #(
        .DATA_W        (3),
        .SYNC_STAGES   (2),
        .NOTICE_CYCLES (10),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .request    (request),
        .valid      (valid),
        .data_in    (data_in),
        .ack        (ack),
        .data_out   (data_out),
        .data_strobe(data_strobe),
        .notice     (notice),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input int bound, output int cyc);
        cyc = 0;
        while (ack !== lvl && cyc < bound) begin
            tick();
            cyc++;
        end
        if (ack !== lvl) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack wait: ack=%0b after %0d cycles, expected %0b", ack, cyc, lvl);
        end
    endtask

    task automatic push_exp(input logic [2:0] d);
        exp_q.push_back(d);
        n_pushed++;
    endtask

    task automatic measure_notice(output int n);
        n = 0;
        @(negedge clk);
        while (notice === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // One master transaction: request, ack seen, valid+data after 'delay', drop on ack low.
    task automatic transfer(input logic [2:0] d, input int delay, input int hold, input string name);
        int c;
        int hi;
        request = 1'b1;
        wait_ack(1'b1, 20, c);
        check({name, " ack latency"}, c, 3);
        repeat (delay) tick();
        push_exp(d);
        data_in = d;
        valid   = 1'b1;
        wait_ack(1'b0, 20, c);
        check({name, " valid to ack low"}, c, 4);
        last_data = d;
        hi = 0;
        repeat (hold) begin
            tick();
            if (ack === 1'b1) hi++;
        end
        if (hold > 0) check({name, " ack during stale hold"}, hi, 0);
        request = 1'b0;
        valid   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && data_strobe === 1'b1) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                check("unexpected strobe", 1, 0);
            end else begin
                check("scoreboard data_out", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        int hi;
        int s0;
        n_checks  = 0;
        n_fail    = 0;
        n_strobes = 0;
        n_pushed  = 0;
        last_data = 3'd0;
        rst_n     = 1'b0;
        request   = 1'b0;
        valid     = 1'b0;
        data_in   = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset ack", ack, 0);
        check("reset data_out", data_out, 0);
        check("reset strobe", data_strobe, 0);
        check("reset notice", notice, 0);
        check("reset timeout_err", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Normal transfer
        transfer(3'b101, 20, 0, "normal");
        measure_notice(n);
        check("normal notice cycles", n, 10);
        check("normal data_out", data_out, 5);
        check("normal timeout_err", timeout_err, 0);
        repeat (4) tick();

        // Glitch rejection
        request = 1'b1;
        wait_ack(1'b1, 20, c);
        check("glitch ack latency", c, 3);
        repeat (5) tick();
        data_in = 3'b111;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        check("glitch ack held", ack, 1);
        check("glitch data_out kept", data_out, 5);
        push_exp(3'b010);
        data_in = 3'b010;
        valid   = 1'b1;
        wait_ack(1'b0, 20, c);
        check("glitch valid to ack low", c, 4);
        request   = 1'b0;
        valid     = 1'b0;
        last_data = 3'b010;
        tick();
        check("glitch data_out", data_out, 2);
        repeat (4) tick();

        // Timeout
        request = 1'b1;
        wait_ack(1'b1, 20, c);
        check("timeout ack latency", c, 3);
        wait_ack(1'b0, 100, c);
        check("timeout ack high cycles", c, 50);
        check("timeout_err set", timeout_err, 1);
        check("timeout data_out kept", data_out, int'(last_data));
        hi = 0;
        repeat (10) begin
            tick();
            if (ack === 1'b1) hi++;
        end
        check("timeout release holds ack low", hi, 0);
        request = 1'b0;
        repeat (4) tick();
        transfer(3'b011, 3, 0, "after timeout");
        tick();
        check("timeout_err cleared", timeout_err, 0);
        check("after timeout data_out", data_out, 3);
        repeat (4) tick();

        // Stale request: hold request and valid after capture
        transfer(3'b100, 2, 30, "stale");
        repeat (4) tick();
        transfer(3'b001, 2, 0, "re-ack");
        check("re-ack data_out", data_out, 1);
        repeat (4) tick();

        // Back-to-back captures four cycles apart
        s0 = n_strobes;
        request = 1'b1;
        wait_ack(1'b1, 20, c);
        data_in = 3'b001;
        valid   = 1'b1;
        push_exp(3'b001);
        tick();
        tick();
        request = 1'b0;
        valid   = 1'b0;
        tick();
        request = 1'b1;
        valid   = 1'b1;
        data_in = 3'b110;
        push_exp(3'b110);
        wait_ack(1'b0, 20, c);
        check("b2b first ack low", c, 1);
        wait_ack(1'b1, 20, c);
        check("b2b second ack rise", c, 2);
        wait_ack(1'b0, 20, c);
        check("b2b second ack low", c, 2);
        request   = 1'b0;
        valid     = 1'b0;
        last_data = 3'b110;
        measure_notice(n);
        check("b2b notice cycles", n, 10);
        check("b2b strobes", n_strobes - s0, 2);
        check("b2b data_out", data_out, 6);
        repeat (4) tick();

        // Reset mid-transfer
        transfer(3'b100, 3, 0, "pre-reset");
        tick();
        tick();
        request = 1'b1;
        wait_ack(1'b1, 20, c);
        check("pre-reset notice lit", notice, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset ack", ack, 0);
        check("async reset notice", notice, 0);
        check("async reset data_out", data_out, 0);
        check("async reset timeout_err", timeout_err, 0);
        request   = 1'b0;
        last_data = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        transfer(3'b101, 3, 0, "post-reset");
        tick();
        check("post-reset data_out", data_out, 5);
        repeat (4) tick();

        check("scoreboard drained", exp_q.size(), 0);
        check("total strobes", n_strobes, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
